// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
package rv32i_types;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter, wraps modulo 2^W.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage RV32I pipeline: register enables,
// per-stage valid bits and hazard performance counters.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             bubble,
    input  logic             redirect,
    output logic             load_pc,
    output logic             pc_redirect,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             valid_id,
    output logic             valid_ex,
    output logic             valid_mem,
    output logic             valid_wb,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic [CNT_W-1:0] cnt_freeze,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_redirect
);

    logic        r_valid_id;
    logic        r_valid_ex;
    logic        r_valid_mem;
    logic        r_valid_wb;
    pipe_state_t r_state;
    pipe_state_t w_state_nxt;
    logic        w_freeze;
    logic        w_lu;
    logic        w_rd;

    // Qualified events; a frozen EX keeps its bubble/redirect for the next cycle.
    assign w_freeze = (imem_read & ~imem_resp) | (dmem_req & r_valid_mem & ~dmem_resp);
    assign w_lu     = bubble & r_valid_ex & ~w_freeze;
    assign w_rd     = redirect & r_valid_ex & ~w_freeze & ~w_lu;

    always_comb begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        pc_redirect = w_rd;
        if (w_freeze) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (w_lu) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_id  <= 1'b0;
            r_valid_ex  <= 1'b0;
            r_valid_mem <= 1'b0;
            r_valid_wb  <= 1'b0;
        end else if (w_freeze) begin
            r_valid_id  <= r_valid_id;
            r_valid_ex  <= r_valid_ex;
            r_valid_mem <= r_valid_mem;
            r_valid_wb  <= r_valid_wb;
        end else if (w_lu) begin
            r_valid_mem <= 1'b0;
            r_valid_wb  <= r_valid_mem;
        end else if (w_rd) begin
            // The branch itself moves on to MEM; the two younger instructions die.
            r_valid_id  <= 1'b0;
            r_valid_ex  <= 1'b0;
            r_valid_mem <= 1'b1;
            r_valid_wb  <= r_valid_mem;
        end else begin
            r_valid_id  <= imem_resp;
            r_valid_ex  <= r_valid_id;
            r_valid_mem <= r_valid_ex;
            r_valid_wb  <= r_valid_mem;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_freeze)  w_state_nxt = FROZEN;
            FROZEN:  if (!w_freeze) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign valid_id     = r_valid_id;
    assign valid_ex     = r_valid_ex;
    assign valid_mem    = r_valid_mem;
    assign valid_wb     = r_valid_wb;
    assign flush_ex_mem = ~r_valid_mem;
    assign flush_mem_wb = ~r_valid_wb;

    perf_counter #(.W(CNT_W)) u_cnt_freeze (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_freeze),
        .count (cnt_freeze)
    );

    perf_counter #(.W(CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_lu),
        .count (cnt_load_use)
    );

    perf_counter #(.W(CNT_W)) u_cnt_redirect (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_rd),
        .count (cnt_redirect)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors with hand-computed expectations.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             bubble;
    logic             redirect;
    logic             load_pc;
    logic             pc_redirect;
    logic             load_if_id;
    logic             load_id_ex;
    logic             load_ex_mem;
    logic             load_mem_wb;
    logic             valid_id;
    logic             valid_ex;
    logic             valid_mem;
    logic             valid_wb;
    logic             flush_ex_mem;
    logic             flush_mem_wb;
    logic [CNT_W-1:0] cnt_freeze;
    logic [CNT_W-1:0] cnt_load_use;
    logic [CNT_W-1:0] cnt_redirect;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .dmem_req     (dmem_req),
        .dmem_resp    (dmem_resp),
        .bubble       (bubble),
        .redirect     (redirect),
        .load_pc      (load_pc),
        .pc_redirect  (pc_redirect),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .valid_id     (valid_id),
        .valid_ex     (valid_ex),
        .valid_mem    (valid_mem),
        .valid_wb     (valid_wb),
        .flush_ex_mem (flush_ex_mem),
        .flush_mem_wb (flush_mem_wb),
        .cnt_freeze   (cnt_freeze),
        .cnt_load_use (cnt_load_use),
        .cnt_redirect (cnt_redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [5:0] ld;
        logic [3:0] vld;
        logic [31:0] cf;
        logic [31:0] clu;
        logic [31:0] crd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_idx = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // ld = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, pc_redirect}
    // in = {imem_read, imem_resp, dmem_req, dmem_resp, bubble, redirect}
    // v  = {valid_id, valid_ex, valid_mem, valid_wb} seen during this cycle
    task automatic step(input logic rst, input logic [5:0] in, input logic [5:0] ld,
                        input logic [3:0] v, input int cf, input int clu, input int crd);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        {imem_read, imem_resp, dmem_req, dmem_resp, bubble, redirect} = in;
        e.idx = step_idx;
        e.ld  = ld;
        e.vld = v;
        e.cf  = cf;
        e.clu = clu;
        e.crd = crd;
        exp_q.push_back(e);
        step_idx++;
    endtask

    // Monitor: every negedge, compare what the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("loads", e.idx, {26'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, pc_redirect}, {26'd0, e.ld});
                check("valid", e.idx, {28'd0, valid_id, valid_ex, valid_mem, valid_wb}, {28'd0, e.vld});
                check("flush", e.idx, {30'd0, flush_ex_mem, flush_mem_wb}, {30'd0, ~e.vld[1], ~e.vld[0]});
                check("cnt_freeze", e.idx, cnt_freeze, e.cf);
                check("cnt_load_use", e.idx, cnt_load_use, e.clu);
                check("cnt_redirect", e.idx, cnt_redirect, e.crd);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {imem_read, imem_resp, dmem_req, dmem_resp, bubble, redirect} = 6'b0;
        // reset, fill the pipe, then freeze on a dmem wait with valid_mem=1
        step(1'b0, 6'b000000, 6'b111110, 4'b0000, 0, 0, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b0000, 0, 0, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b1000, 0, 0, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b1100, 0, 0, 0);
        step(1'b1, 6'b000000, 6'b111110, 4'b1110, 0, 0, 0);
        step(1'b1, 6'b001000, 6'b000000, 4'b0111, 0, 0, 0);
        step(1'b1, 6'b001000, 6'b000000, 4'b0111, 1, 0, 0);
        step(1'b1, 6'b001000, 6'b000000, 4'b0111, 2, 0, 0);
        // reset asserted mid-freeze, checked before the next rising edge
        step(1'b0, 6'b001000, 6'b111110, 4'b0000, 0, 0, 0);
        step(1'b0, 6'b000000, 6'b111110, 4'b0000, 0, 0, 0);
        // straight-line fill: valid_wb on the 4th edge after the first response
        step(1'b1, 6'b110000, 6'b111110, 4'b0000, 0, 0, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b1000, 0, 0, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b1100, 0, 0, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b1110, 0, 0, 0);
        // load-use, then redirect
        step(1'b1, 6'b110010, 6'b000110, 4'b1111, 0, 0, 0);
        step(1'b1, 6'b110001, 6'b111111, 4'b1101, 0, 1, 0);
        step(1'b1, 6'b110000, 6'b111110, 4'b0010, 0, 1, 1);
        step(1'b1, 6'b110000, 6'b111110, 4'b1001, 0, 1, 1);
        step(1'b1, 6'b110000, 6'b111110, 4'b1100, 0, 1, 1);
        // bubble and redirect together: load-use wins, redirect taken next cycle
        step(1'b1, 6'b110011, 6'b000110, 4'b1110, 0, 1, 1);
        step(1'b1, 6'b110001, 6'b111111, 4'b1101, 0, 2, 1);
        step(1'b1, 6'b110000, 6'b111110, 4'b0010, 0, 2, 2);
        step(1'b1, 6'b110000, 6'b111110, 4'b1001, 0, 2, 2);
        step(1'b1, 6'b110000, 6'b111110, 4'b1100, 0, 2, 2);
        // 5-cycle dmem wait with a redirect pending in EX
        step(1'b1, 6'b111001, 6'b000000, 4'b1110, 0, 2, 2);
        step(1'b1, 6'b111001, 6'b000000, 4'b1110, 1, 2, 2);
        step(1'b1, 6'b111001, 6'b000000, 4'b1110, 2, 2, 2);
        step(1'b1, 6'b111001, 6'b000000, 4'b1110, 3, 2, 2);
        step(1'b1, 6'b111001, 6'b000000, 4'b1110, 4, 2, 2);
        step(1'b1, 6'b111101, 6'b111111, 4'b1110, 5, 2, 2);
        step(1'b1, 6'b000000, 6'b111110, 4'b0011, 5, 2, 3);
        // imem wait freeze
        step(1'b1, 6'b100000, 6'b000000, 4'b0001, 5, 2, 3);
        step(1'b1, 6'b010000, 6'b111110, 4'b0001, 6, 2, 3);
        step(1'b1, 6'b010000, 6'b111110, 4'b1000, 6, 2, 3);
        step(1'b1, 6'b010000, 6'b111110, 4'b1100, 6, 2, 3);
        // dmem wait together with bubble: freeze only, load-use after
        step(1'b1, 6'b001010, 6'b000000, 4'b1110, 6, 2, 3);
        step(1'b1, 6'b001110, 6'b000110, 4'b1110, 7, 2, 3);
        step(1'b1, 6'b000000, 6'b111110, 4'b1101, 7, 3, 3);
        step(1'b1, 6'b000000, 6'b111110, 4'b0110, 7, 3, 3);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
